gcd_scheduler: RTL and testbench
================================

Name: gcd_scheduler

Overview:
- Shares one gcd engine between NREQ requesters using round-robin arbitration.
- Per transaction: captures operands, loads the engine, waits for its result, returns it with the requester ID, then clears the engine for the next job.
- Short-circuits zero operands without using the engine.
- A watchdog bounds engine latency and flags hung jobs.

Parameters:
- XLEN, 16, operand/result width
- NREQ, 4, number of requesters (≥2)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- TMO_CYCLES, 1024, maximum cycles in LOAD+BUSY before abort

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  async active-low reset
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester accept (one-hot or zero)
- req_a_i  in  NREQ*XLEN  operand A, slice k = requester k
- req_b_i  in  NREQ*XLEN  operand B, slice k = requester k
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_id_o  out  IDW  requester index of response
- rsp_gcd_o  out  XLEN  result
- rsp_err_o  out  1  1 = watchdog abort
- busy_o  out  1  high in any state but IDLE
- eng_resetn_o  out  1  engine reset, active-low
- eng_ld_o  out  1  engine load strobe
- eng_a_o  out  XLEN  engine operand A
- eng_b_o  out  XLEN  engine operand B
- eng_ready_i  in  1  engine idle, can accept ld
- eng_valid_i  in  1  engine result valid (level)
- eng_gcd_i  in  XLEN  engine result

Behaviour:
- Clock is clk_i. Reset resetn_i is asynchronous, active-low.
- Reset values:
  - state=IDLE; rr pointer=0; watchdog=0.
  - All outputs 0, except eng_resetn_o=0 while resetn_i=0, then 1.
- States: IDLE, LOAD, BUSY, RESP, CLR.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, searching from the rr pointer upward, wrapping modulo NREQ.
  - req_ready_o[winner]=1 combinationally, only in IDLE. All other req_ready_o bits stay 0.
  - On the handshake edge: latch A, B and the winner ID; rr pointer <= (winner+1) mod NREQ.
  - Next state:
    - A=0 or B=0 → RESP, with result = A|B (so 0,0 gives 0) and err=0; the engine is untouched.
    - Otherwise → LOAD.
  - No valid requests → stay in IDLE.
- LOAD:
  - eng_a_o/eng_b_o driven from the latched operands in every non-IDLE state; 0 in IDLE.
  - eng_ld_o=1 for exactly the one cycle where eng_ready_i=1; then → BUSY.
  - If eng_ready_i=0, remain in LOAD.
- BUSY: on the first cycle with eng_valid_i=1, latch eng_gcd_i, set err=0, → RESP.
- Watchdog:
  - Counts every cycle spent in LOAD or BUSY; cleared on entry to LOAD.
  - On reaching TMO_CYCLES: → RESP with result=0, err=1.
  - Timeout takes priority over a same-cycle eng_valid_i.
- RESP:
  - rsp_valid_o=1 with rsp_id_o/rsp_gcd_o/rsp_err_o held stable until rsp_ready_i=1.
  - Then → CLR for engine jobs (including aborts); bypass jobs go straight to IDLE.
- CLR: eng_resetn_o=0 for exactly one cycle, then → IDLE.
- Minimum throughput: bypass job 2 cycles; engine job = engine latency + 4 cycles, with rsp_ready_i held high.
- Requests are never dropped; a requester must hold valid and operands until its ready.
- All request traffic is ignored outside IDLE.
- Reset mid-operation: the job is abandoned, no response is issued, the rr pointer returns to 0, and the engine is held in reset.

Test Plan:
- Single engine job: req0 (48,18) → one eng_ld_o pulse with eng_a_o=48, eng_b_o=18. Then rsp_id=0, gcd=6, err=0, followed by one eng_resetn_o low cycle.
- Round-robin contention:
  - Stimulus: req1 (1701,199), req2 (22000,19900) and req3 (42000,1990) all asserted at the same time from reset.
  - Grant order 1, 2, 3, with results 1, 100, 10.
  - Then req0 and req1 (40664,57408) both valid: req0 is served first, then req1 returns 2392.
- Zero bypass:
  - req2 (0,289) → rsp gcd=289 two cycles after the handshake, with no eng_ld_o or eng_resetn_o activity.
  - (0,0) → gcd=0, err=0.
- Backpressure:
  - Hold rsp_ready_i=0 for 20 cycles after rsp_valid_o rises: outputs stay stable and req_ready_o stays 0.
  - Release rsp_ready_i: exactly one response is consumed.
- Watchdog:
  - Engine stub keeps eng_valid_i=0 with TMO_CYCLES=16.
  - rsp_err_o=1 and gcd=0 exactly 16 cycles after LOAD entry, followed by a CLR pulse.
  - A stub with eng_ready_i=0 also times out.
- Async reset in BUSY:
  - Drop resetn_i for 3 ns between clock edges: all outputs clear immediately and no response is issued.
  - After release, req3 (17,289) → gcd=17, rsp_id=3.

Source files
------------

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin scheduler sharing one gcd engine between requesters
//
// Ports:
//   clk_i, resetn_i            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester handshake (ready is one-hot or zero, IDLE only)
//   req_a_i/req_b_i            packed operands, slice k belongs to requester k
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_id_o/rsp_gcd_o/rsp_err_o  requester index, result, watchdog-abort flag
//   busy_o                     high whenever a job is in flight
//   eng_resetn_o/eng_ld_o      engine reset (active-low) and load strobe
//   eng_a_o/eng_b_o            engine operands
//   eng_ready_i/eng_valid_i/eng_gcd_i  engine status and result
module gcd_scheduler #(
    parameter int XLEN       = 16,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int TMO_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [XLEN-1:0]      rsp_gcd_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 eng_resetn_o,
    output logic                 eng_ld_o,
    output logic [XLEN-1:0]      eng_a_o,
    output logic [XLEN-1:0]      eng_b_o,
    input  logic                 eng_ready_i,
    input  logic                 eng_valid_i,
    input  logic [XLEN-1:0]      eng_gcd_i
);

    localparam int WDW = $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_RESP,
        S_CLR
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [XLEN-1:0] gcd_q, gcd_d;
    logic            err_q, err_d;
    logic            byp_q, byp_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    // Round-robin winner: first valid requester at or above the pointer, wrapping.
    logic            win_any;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  rr_next;
    logic [XLEN-1:0] win_a;
    logic [XLEN-1:0] win_b;
    int              idx;

    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (!win_any && req_valid_i[idx]) begin
                win_any = 1'b1;
                win_id  = IDW'(idx);
            end
        end
        win_a   = req_a_i[int'(win_id)*XLEN +: XLEN];
        win_b   = req_b_i[int'(win_id)*XLEN +: XLEN];
        rr_next = IDW'((int'(win_id) + 1) % NREQ);
    end

    // The watchdog counter holds the number of LOAD/BUSY cycles already
    // completed, so this cycle is the TMO_CYCLES-th one when it reads TMO-1.
    logic timeout;
    assign timeout = ((state_q == S_LOAD) || (state_q == S_BUSY)) &&
                     (wdog_q == WDW'(TMO_CYCLES - 1));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            byp_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            byp_q   <= byp_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        byp_d   = byp_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    a_d  = win_a;
                    b_d  = win_b;
                    id_d = win_id;
                    rr_d = rr_next;
                    if ((win_a == '0) || (win_b == '0)) begin
                        // gcd(0,x) = x and gcd(0,0) is taken as 0: no engine needed.
                        gcd_d   = win_a | win_b;
                        err_d   = 1'b0;
                        byp_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        byp_d   = 1'b0;
                        wdog_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                wdog_d = wdog_q + WDW'(1);
                if (timeout) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (eng_ready_i) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + WDW'(1);
                if (timeout) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (eng_valid_i) begin
                    gcd_d   = eng_gcd_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = byp_q ? S_IDLE : S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o  = '0;
        rsp_valid_o  = 1'b0;
        rsp_id_o     = '0;
        rsp_gcd_o    = '0;
        rsp_err_o    = 1'b0;
        busy_o       = (state_q != S_IDLE);
        // The engine is held in reset with the scheduler, and pulsed low in CLR.
        eng_resetn_o = resetn_i && (state_q != S_CLR);
        eng_ld_o     = 1'b0;
        eng_a_o      = '0;
        eng_b_o      = '0;
        if (state_q != S_IDLE) begin
            eng_a_o = a_q;
            eng_b_o = b_q;
        end
        unique case (state_q)
            S_IDLE: begin
                if (resetn_i && win_any) begin
                    req_ready_o[win_id] = 1'b1;
                end
            end
            S_LOAD: begin
                // Skip the load when aborting: the engine is cleared right after.
                eng_ld_o = eng_ready_i && !timeout;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = id_q;
                rsp_gcd_o   = gcd_q;
                rsp_err_o   = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb/tb_gcd_scheduler.sv - self-checking bench for gcd_scheduler with engine stub and scoreboard
module tb_gcd_scheduler;
    localparam int XLEN = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 16;
    localparam int M_NORMAL = 0;
    localparam int M_HANG   = 1;
    localparam int M_NOTRDY = 2;

    logic                 clk = 1'b0;
    logic                 resetn_i = 1'b0;
    logic [NREQ-1:0]      req_valid_i = '0;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*XLEN-1:0] req_a_i = '0;
    logic [NREQ*XLEN-1:0] req_b_i = '0;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i = 1'b0;
    logic [IDW-1:0]       rsp_id_o;
    logic [XLEN-1:0]      rsp_gcd_o;
    logic                 rsp_err_o;
    logic                 busy_o;
    logic                 eng_resetn_o;
    logic                 eng_ld_o;
    logic [XLEN-1:0]      eng_a_o;
    logic [XLEN-1:0]      eng_b_o;
    logic                 eng_ready_i;
    logic                 eng_valid_i;
    logic [XLEN-1:0]      eng_gcd_i;

    gcd_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW), .TMO_CYCLES(TMO)) dut (
        .clk_i(clk), .resetn_i(resetn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_gcd_o(rsp_gcd_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .eng_resetn_o(eng_resetn_o), .eng_ld_o(eng_ld_o),
        .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
        .eng_ready_i(eng_ready_i), .eng_valid_i(eng_valid_i), .eng_gcd_i(eng_gcd_i)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine stub: loads on ld, produces gcd after stub_lat cycles (never in HANG).
    int              mode = M_NORMAL;
    int              lat_next = 1;
    int              lat_force = 0;
    logic            stub_rdy = 1'b1;
    logic            stub_vld = 1'b0;
    logic            stub_busy = 1'b0;
    logic [XLEN-1:0] stub_res = '0;
    int              stub_cnt = 0;
    int              stub_lat = 0;

    always @(posedge clk or negedge eng_resetn_o) begin
        if (!eng_resetn_o) begin
            stub_rdy  <= 1'b1;
            stub_vld  <= 1'b0;
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (eng_ld_o && eng_ready_i) begin
            stub_rdy  <= 1'b0;
            stub_busy <= 1'b1;
            stub_cnt  <= lat_next;
            stub_lat  <= lat_next;
            stub_res  <= XLEN'(gcd_ref(32'(eng_a_o), 32'(eng_b_o)));
        end else if (stub_busy && !stub_vld) begin
            if (stub_cnt > 1) stub_cnt <= stub_cnt - 1;
            else if (mode != M_HANG) stub_vld <= 1'b1;
        end
    end
    assign eng_ready_i = stub_rdy && (mode != M_NOTRDY);
    assign eng_valid_i = stub_vld;
    assign eng_gcd_i   = stub_vld ? stub_res : 16'hdead;

    // Requester job lists.
    logic [XLEN-1:0] ja [NREQ][64];
    logic [XLEN-1:0] jb [NREQ][64];
    int              jn [NREQ];
    int              jp [NREQ];
    bit              grant_pend [NREQ];
    int              rsp_mode = 1;  // 0 random, 1 always ready, 2 held off

    task automatic add_job(input int k, input int unsigned a, input int unsigned b);
        ja[k][jn[k]] = XLEN'(a);
        jb[k][jn[k]] = XLEN'(b);
        jn[k]++;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        lat_next = (lat_force != 0) ? lat_force : int'($urandom_range(1, 8));
        for (int k = 0; k < NREQ; k++) begin
            if (grant_pend[k]) begin
                jp[k]++;
                grant_pend[k] = 1'b0;
            end
            if (jp[k] < jn[k]) begin
                req_valid_i[k] = 1'b1;
                req_a_i[k*XLEN +: XLEN] = ja[k][jp[k]];
                req_b_i[k*XLEN +: XLEN] = jb[k][jp[k]];
            end else begin
                req_valid_i[k] = 1'b0;
                req_a_i[k*XLEN +: XLEN] = XLEN'($urandom);
                req_b_i[k*XLEN +: XLEN] = XLEN'($urandom);
            end
        end
        case (rsp_mode)
            0: rsp_ready_i = ($urandom_range(0, 3) != 0);
            1: rsp_ready_i = 1'b1;
            default: rsp_ready_i = 1'b0;
        endcase
    end

    // Scoreboard / model state.
    bit              model_rst = 1'b0;
    int              rr_m = 0;
    bit              in_job = 1'b0;
    bit              clr_pend = 1'b0;
    int              j_id, j_mode, hs_edge, ld_cnt;
    logic [XLEN-1:0] j_a, j_b;
    bit              j_byp, seen_rsp;
    bit              hold = 1'b0;
    logic [IDW-1:0]  h_id;
    logic [XLEN-1:0] h_gcd;
    logic            h_err;
    logic [XLEN-1:0] lda = '0, ldb = '0;
    int              log_id[$];
    int              log_gcd[$];
    int              log_err[$];

    initial forever begin
        logic [NREQ-1:0] exp_rdy;
        int w, expd, exp_gcd, exp_err, exp_ld;
        @(negedge clk);
        if (!resetn_i || model_rst) begin
            rr_m = 0; in_job = 0; clr_pend = 0; hold = 0; model_rst = 0;
        end
        if (resetn_i) begin
            if (in_job) begin
                chk("eng_a_held", eng_a_o, j_a);
                chk("eng_b_held", eng_b_o, j_b);
            end
            if (clr_pend) begin
                chk("clr_pulse", eng_resetn_o, 0);
                chk("clr_busy", busy_o, 1);
                chk("clr_ready", req_ready_o, 0);
                chk("clr_rsp_valid", rsp_valid_o, 0);
                clr_pend = 0;
                in_job = 0;
            end else begin
                chk("eng_resetn_high", eng_resetn_o, 1);
                chk("busy", busy_o, in_job);
                exp_rdy = '0;
                w = -1;
                if (!in_job) begin
                    for (int i = 0; i < NREQ; i++)
                        if (w < 0 && req_valid_i[(rr_m + i) % NREQ]) w = (rr_m + i) % NREQ;
                    if (w >= 0) exp_rdy[w] = 1'b1;
                end
                chk("req_ready", req_ready_o, exp_rdy);
                if (!in_job) begin
                    chk("idle_outputs", {rsp_valid_o, eng_ld_o, eng_a_o, eng_b_o}, 0);
                end else begin
                    if (eng_ld_o) begin
                        ld_cnt++;
                        lda = eng_a_o;
                        ldb = eng_b_o;
                    end
                    if (hold) begin
                        chk("rsp_hold_valid", rsp_valid_o, 1);
                        chk("rsp_hold_fields", {rsp_id_o, rsp_gcd_o, rsp_err_o}, {h_id, h_gcd, h_err});
                    end
                    exp_err = (!j_byp && (j_mode != M_NORMAL || stub_lat + 2 >= TMO)) ? 1 : 0;
                    if (rsp_valid_o && !seen_rsp) begin
                        seen_rsp = 1;
                        expd = j_byp ? 0 : (exp_err != 0) ? TMO : stub_lat + 2;
                        chk("rsp_delay", cyc - hs_edge, expd);
                    end
                    if (rsp_valid_o && rsp_ready_i) begin
                        exp_gcd = (exp_err != 0) ? 0 : j_byp ? int'(j_a | j_b) :
                                  int'(gcd_ref(32'(j_a), 32'(j_b)));
                        exp_ld = (j_byp || j_mode == M_NOTRDY) ? 0 : 1;
                        chk("rsp_id", rsp_id_o, j_id);
                        chk("rsp_gcd", rsp_gcd_o, exp_gcd);
                        chk("rsp_err", rsp_err_o, exp_err);
                        chk("ld_count", ld_cnt, exp_ld);
                        log_id.push_back(int'(rsp_id_o));
                        log_gcd.push_back(int'(rsp_gcd_o));
                        log_err.push_back(int'(rsp_err_o));
                        if (j_byp) in_job = 0;
                        else clr_pend = 1;
                    end
                    hold = rsp_valid_o && !rsp_ready_i;
                    h_id = rsp_id_o; h_gcd = rsp_gcd_o; h_err = rsp_err_o;
                end
                if ((req_ready_o & req_valid_i) != '0) begin
                    w = 0;
                    for (int k = 0; k < NREQ; k++) if (req_ready_o[k] && req_valid_i[k]) w = k;
                    j_id = w;
                    j_a = req_a_i[w*XLEN +: XLEN];
                    j_b = req_b_i[w*XLEN +: XLEN];
                    j_byp = (j_a == 0) || (j_b == 0);
                    j_mode = mode;
                    hs_edge = cyc + 1;
                    ld_cnt = 0;
                    seen_rsp = 0;
                    in_job = 1;
                    hold = 0;
                    rr_m = (w + 1) % NREQ;
                    grant_pend[w] = 1'b1;
                end
            end
        end
    end

    task automatic clear_log();
        log_id.delete();
        log_gcd.delete();
        log_err.delete();
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            #1;
            done = !in_job && !busy_o && !clr_pend;
            for (int k = 0; k < NREQ; k++) if (jp[k] != jn[k] || grant_pend[k]) done = 0;
        end
        if (!done) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_req_ready"}, req_ready_o, 0);
        chk({tag, "_eng_resetn"}, eng_resetn_o, 0);
        chk({tag, "_eng_ld"}, eng_ld_o, 0);
        chk({tag, "_eng_ab"}, {eng_a_o, eng_b_o}, 0);
        chk({tag, "_rsp_fields"}, {rsp_id_o, rsp_gcd_o, rsp_err_o}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn_i = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 resetn_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit seen;
        for (int k = 0; k < NREQ; k++) begin
            jn[k] = 0; jp[k] = 0; grant_pend[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("por");
        @(posedge clk);
        #1 resetn_i = 1'b1;
        #1 chk("por_eng_resetn_release", eng_resetn_o, 1);

        // Single engine job.
        clear_log();
        add_job(0, 48, 18);
        wait_idle(200);
        chk("single_count", log_id.size(), 1);
        if (log_id.size() >= 1) begin
            chk("single_id", log_id[0], 0);
            chk("single_gcd", log_gcd[0], 6);
            chk("single_err", log_err[0], 0);
        end
        chk("single_ld_a", lda, 48);
        chk("single_ld_b", ldb, 18);

        // Round-robin contention from reset.
        do_reset();
        clear_log();
        add_job(1, 1701, 199);
        add_job(2, 22000, 19900);
        add_job(3, 42000, 1990);
        wait_idle(300);
        chk("rr_count", log_id.size(), 3);
        if (log_id.size() >= 3) begin
            chk("rr_id0", log_id[0], 1);  chk("rr_gcd0", log_gcd[0], 1);
            chk("rr_id1", log_id[1], 2);  chk("rr_gcd1", log_gcd[1], 100);
            chk("rr_id2", log_id[2], 3);  chk("rr_gcd2", log_gcd[2], 10);
        end
        clear_log();
        add_job(0, 12, 8);
        add_job(1, 40664, 57408);
        wait_idle(300);
        chk("rr2_count", log_id.size(), 2);
        if (log_id.size() >= 2) begin
            chk("rr2_id0", log_id[0], 0);  chk("rr2_gcd0", log_gcd[0], 4);
            chk("rr2_id1", log_id[1], 1);  chk("rr2_gcd1", log_gcd[1], 2392);
        end

        // Zero bypass.
        clear_log();
        add_job(2, 0, 289);
        add_job(2, 0, 0);
        wait_idle(100);
        chk("byp_count", log_id.size(), 2);
        if (log_id.size() >= 2) begin
            chk("byp_gcd0", log_gcd[0], 289); chk("byp_err0", log_err[0], 0);
            chk("byp_gcd1", log_gcd[1], 0);   chk("byp_err1", log_err[1], 0);
        end

        // Backpressure.
        rsp_mode = 2;
        clear_log();
        add_job(1, 9, 6);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #1 seen = rsp_valid_o;
        end
        chk("bp_rsp_seen", seen, 1);
        add_job(2, 35, 21);
        repeat (20) @(negedge clk);
        #1;
        chk("bp_valid_held", rsp_valid_o, 1);
        chk("bp_ready_low", req_ready_o, 0);
        chk("bp_none_consumed", log_id.size(), 0);
        rsp_mode = 1;
        wait_idle(200);
        chk("bp_count", log_id.size(), 2);
        if (log_id.size() >= 2) begin
            chk("bp_id0", log_id[0], 1);  chk("bp_gcd0", log_gcd[0], 3);
            chk("bp_id1", log_id[1], 2);  chk("bp_gcd1", log_gcd[1], 7);
        end

        // Watchdog: hung engine, never-ready engine, and the same-cycle collision.
        clear_log();
        mode = M_HANG;
        add_job(0, 30, 12);
        wait_idle(200);
        mode = M_NOTRDY;
        add_job(1, 30, 12);
        wait_idle(200);
        mode = M_NORMAL;
        lat_force = 14;
        add_job(2, 30, 12);
        wait_idle(200);
        lat_force = 13;
        add_job(3, 30, 12);
        wait_idle(200);
        lat_force = 0;
        chk("wd_count", log_id.size(), 4);
        if (log_id.size() >= 4) begin
            chk("wd_hang_err", log_err[0], 1);   chk("wd_hang_gcd", log_gcd[0], 0);
            chk("wd_nrdy_err", log_err[1], 1);   chk("wd_nrdy_gcd", log_gcd[1], 0);
            chk("wd_tie_err", log_err[2], 1);    chk("wd_tie_gcd", log_gcd[2], 0);
            chk("wd_late_err", log_err[3], 0);   chk("wd_late_gcd", log_gcd[3], 6);
        end

        // Randomised traffic with random response backpressure.
        rsp_mode = 0;
        clear_log();
        for (int i = 0; i < 48; i++) begin
            int unsigned g, a, b;
            g = $urandom_range(1, 60);
            a = ($urandom_range(0, 9) == 0) ? 0 : g * $urandom_range(1, 1000);
            b = ($urandom_range(0, 9) == 0) ? 0 : g * $urandom_range(1, 1000);
            add_job(int'($urandom_range(0, NREQ - 1)), a, b);
        end
        wait_idle(5000);
        chk("rand_count", log_id.size(), 48);
        rsp_mode = 1;

        // Asynchronous reset while the engine is busy.
        clear_log();
        mode = M_HANG;
        add_job(0, 100, 75);
        repeat (6) @(posedge clk);
        #0.5;
        chk("pre_rst_busy", busy_o, 1);
        @(posedge clk);
        #1 resetn_i = 1'b0;
        #1 check_reset_outputs("async");
        #2 resetn_i = 1'b1;
        model_rst = 1'b1;
        mode = M_NORMAL;
        add_job(3, 17, 289);
        wait_idle(200);
        chk("post_rst_count", log_id.size(), 1);
        if (log_id.size() >= 1) begin
            chk("post_rst_id", log_id[0], 3);
            chk("post_rst_gcd", log_gcd[0], 17);
            chk("post_rst_err", log_err[0], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
